// File: rtl/muldiv_if.sv
// Execute-stage <-> HI/LO sequencer bundle: decoded op bits, operands, handshake and results.
interface muldiv_if;
    logic        valid_i;
    logic        op_mult;
    logic        op_multu;
    logic        op_div;
    logic        op_divu;
    logic        op_mthi;
    logic        op_mtlo;
    logic        op_mfhi;
    logic        op_mflo;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        ready_i;
    logic        cancel_i;
    logic        done_o;
    logic [31:0] rdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic [31:0] perfcnt_muldiv_stall;

    modport master (
        output valid_i, op_mult, op_multu, op_div, op_divu,
               op_mthi, op_mtlo, op_mfhi, op_mflo,
               src1_i, src2_i, ready_i, cancel_i,
        input  done_o, rdata_o, hi_o, lo_o, busy_o, perfcnt_muldiv_stall
    );

    modport slave (
        input  valid_i, op_mult, op_multu, op_div, op_divu,
               op_mthi, op_mtlo, op_mfhi, op_mflo,
               src1_i, src2_i, ready_i, cancel_i,
        output done_o, rdata_o, hi_o, lo_o, busy_o, perfcnt_muldiv_stall
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: 2-cycle multiply, 32-step restoring divide, moves to/from HI/LO.
// Stalls execute via done_o until the result is ready; HI/LO commit only on fire; cancel aborts.
module muldiv_ctrl (
    input  logic     clk,
    input  logic     resetn,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t       state, state_nxt;
    logic         long_op, is_mul_op, done, fire, accept;
    logic         s1, s2;
    logic [31:0]  abs1, abs2;

    logic         is_mul;
    logic [32:0]  mul_a, mul_b;
    logic [63:0]  prod;
    logic signed [65:0] prod_full;
    logic [31:0]  dvd, dvs, rem;
    logic [4:0]   cnt;
    logic         sq, sr;
    logic [32:0]  trial;
    logic [31:0]  res_hi, res_lo;
    logic [31:0]  hi, lo, stall_cnt;

    assign long_op   = bus.op_mult | bus.op_multu | bus.op_div | bus.op_divu;
    assign is_mul_op = bus.op_mult | bus.op_multu;
    assign accept    = (state == IDLE) && bus.valid_i && long_op && !bus.cancel_i;

    assign s1   = bus.op_div & bus.src1_i[31];
    assign s2   = bus.op_div & bus.src2_i[31];
    assign abs1 = s1 ? 32'd0 - bus.src1_i : bus.src1_i;
    assign abs2 = s2 ? 32'd0 - bus.src2_i : bus.src2_i;

    assign done = (state == IDLE) ? !(bus.valid_i && long_op) : (state == DONE);
    assign fire = bus.valid_i && done && bus.ready_i && !bus.cancel_i;

    assign prod_full = $signed(mul_a) * $signed(mul_b);

    // Full-width remainder in the trial keeps unsigned divisors above 2^31 exact.
    assign trial  = {rem, dvd[31]} - {1'b0, dvs};
    assign res_hi = is_mul ? prod[63:32] : (sr ? 32'd0 - rem : rem);
    assign res_lo = is_mul ? prod[31:0]  : (sq ? 32'd0 - dvd : dvd);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_mul_op ? MUL : DIV;
            MUL:  state_nxt = DONE;
            DIV:  if (cnt == 5'd0) state_nxt = DONE;
            DONE: if (fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.cancel_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            is_mul    <= 1'b0;
            mul_a     <= 33'd0;
            mul_b     <= 33'd0;
            prod      <= 64'd0;
            dvd       <= 32'd0;
            dvs       <= 32'd0;
            rem       <= 32'd0;
            cnt       <= 5'd0;
            sq        <= 1'b0;
            sr        <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            if (bus.valid_i && !done) stall_cnt <= stall_cnt + 32'd1;

            case (state)
                IDLE: if (accept) begin
                    is_mul <= is_mul_op;
                    mul_a  <= {bus.op_mult & bus.src1_i[31], bus.src1_i};
                    mul_b  <= {bus.op_mult & bus.src2_i[31], bus.src2_i};
                    dvd    <= abs1;
                    dvs    <= abs2;
                    sq     <= s1 ^ s2;
                    sr     <= s1;
                    rem    <= 32'd0;
                    cnt    <= 5'd31;
                end
                MUL: prod <= prod_full[63:0];
                DIV: begin
                    // Dividend register doubles as the quotient shift register.
                    rem <= trial[32] ? {rem[30:0], dvd[31]} : trial[31:0];
                    dvd <= {dvd[30:0], !trial[32]};
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                default: ;
            endcase

            if (fire) begin
                if (state == DONE) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end else if (bus.op_mthi) begin
                    hi <= bus.src1_i;
                end else if (bus.op_mtlo) begin
                    lo <= bus.src1_i;
                end
            end
        end
    end

    assign bus.done_o               = done;
    assign bus.rdata_o              = bus.op_mfhi ? hi : (bus.op_mflo ? lo : 32'd0);
    assign bus.hi_o                 = hi;
    assign bus.lo_o                 = lo;
    assign bus.busy_o               = (state != IDLE);
    assign bus.perfcnt_muldiv_stall = stall_cnt;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed literal cases plus random ops against an arithmetic reference.
module tb_muldiv_ctrl;

    logic clk = 1'b0;
    logic resetn;

    muldiv_if bus();

    muldiv_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MTHI  = 4;
    localparam int OP_MTLO  = 5;
    localparam int OP_MFHI  = 6;
    localparam int OP_MFLO  = 7;
    localparam int OP_NONE  = 8;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: architectural HI/LO, stall count, and how many cycles the current long op has been held.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_stall = 32'd0;
    int          m_age = 0;
    bit          armed = 1'b0;
    logic [71:0] prev_in = 72'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_op();
        if (bus.op_mult)  return OP_MULT;
        if (bus.op_multu) return OP_MULTU;
        if (bus.op_div)   return OP_DIV;
        if (bus.op_divu)  return OP_DIVU;
        if (bus.op_mthi)  return OP_MTHI;
        if (bus.op_mtlo)  return OP_MTLO;
        if (bus.op_mfhi)  return OP_MFHI;
        if (bus.op_mflo)  return OP_MFLO;
        return OP_NONE;
    endfunction

    function automatic logic [63:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (op)
            OP_MULT:  r = 64'(sa * sb);
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV:   if (b == 32'd0) r = {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
                      else            r = {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                      else            r = {a % b, a / b};
            default:  r = 64'd0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin : cmp
        int          op;
        bit          lng, done_e, fire_e;
        logic [63:0] r;
        logic [31:0] rd_e;
        logic [71:0] cur_in;

        op     = cur_op();
        lng    = (op <= OP_DIVU);
        done_e = !(bus.valid_i && lng) ||
                 (m_age >= (((op == OP_MULT) || (op == OP_MULTU)) ? 2 : 33));
        rd_e   = (op == OP_MFHI) ? m_hi : ((op == OP_MFLO) ? m_lo : 32'd0);
        cur_in = {bus.op_mult, bus.op_multu, bus.op_div, bus.op_divu,
                  bus.op_mthi, bus.op_mtlo, bus.op_mfhi, bus.op_mflo,
                  bus.src1_i, bus.src2_i};

        if (armed) begin
            chk("done",  32'(bus.done_o), 32'(done_e));
            chk("busy",  32'(bus.busy_o), 32'(m_age > 0));
            chk("rdata", bus.rdata_o, rd_e);
            chk("hi",    bus.hi_o, m_hi);
            chk("lo",    bus.lo_o, m_lo);
            chk("stall", bus.perfcnt_muldiv_stall, m_stall);
            if (bus.busy_o) begin
                n_vec++;
                assert (cur_in == prev_in) else begin
                    n_err++;
                    $display("FAIL protocol: inputs %h changed from %h while busy", cur_in, prev_in);
                end
            end
        end
        prev_in = cur_in;

        if (!resetn) begin
            m_hi = 32'd0; m_lo = 32'd0; m_stall = 32'd0; m_age = 0; armed = 1'b1;
        end else begin
            if (bus.valid_i && !done_e) m_stall++;
            fire_e = bus.valid_i && done_e && bus.ready_i && !bus.cancel_i;
            if (bus.cancel_i) begin
                m_age = 0;
            end else if (fire_e) begin
                if (lng) begin
                    r = ref_result(op, bus.src1_i, bus.src2_i);
                    m_hi = r[63:32];
                    m_lo = r[31:0];
                end else if (op == OP_MTHI) begin
                    m_hi = bus.src1_i;
                end else if (op == OP_MTLO) begin
                    m_lo = bus.src1_i;
                end
                m_age = 0;
            end else if (bus.valid_i && lng) begin
                m_age++;
            end
        end
    end

    task automatic set_op(input int op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i  = 1'b1;
        bus.op_mult  = (op == OP_MULT);
        bus.op_multu = (op == OP_MULTU);
        bus.op_div   = (op == OP_DIV);
        bus.op_divu  = (op == OP_DIVU);
        bus.op_mthi  = (op == OP_MTHI);
        bus.op_mtlo  = (op == OP_MTLO);
        bus.op_mfhi  = (op == OP_MFHI);
        bus.op_mflo  = (op == OP_MFLO);
        bus.src1_i   = a;
        bus.src2_i   = b;
    endtask

    task automatic idle();
        set_op(OP_NONE, 32'd0, 32'd0);
        bus.valid_i = 1'b0;
    endtask

    // Called and returns at posedge+1; holds the op until fire or cancel.
    task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input bit rnd_rdy);
        bit ended, dn;
        ended = 1'b0;
        set_op(op, a, b);
        for (int c = 0; c < 100; c++) begin
            bus.ready_i  = rnd_rdy ? ($urandom % 4 != 0) : 1'b1;
            bus.cancel_i = (c == cancel_at);
            @(negedge clk);
            dn = bus.done_o;
            @(posedge clk); #1;
            if (bus.cancel_i || (dn && bus.ready_i)) begin
                ended = 1'b1;
                break;
            end
        end
        bus.cancel_i = 1'b0;
        bus.ready_i  = 1'b1;
        idle();
        chk("drive_end", 32'(ended), 32'd1);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom % 20);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int first_done;
        resetn       = 1'b0;
        bus.ready_i  = 1'b1;
        bus.cancel_i = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // MFLO straight after reset
        set_op(OP_MFLO, 32'd0, 32'd0);
        @(negedge clk);
        chk("mflo_reset", bus.rdata_o, 32'd0);
        chk("mflo_done", 32'(bus.done_o), 32'd1);
        @(posedge clk); #1;

        // MULT 7 x -2 with ready low cycles 2..5
        set_op(OP_MULT, 32'd7, 32'hFFFFFFFE);
        for (int c = 0; c <= 6; c++) begin
            bus.ready_i = !(c >= 2 && c <= 5);
            @(negedge clk);
            if (c >= 2) begin
                chk("hold_done", 32'(bus.done_o), 32'd1);
                chk("hold_hi", bus.hi_o, 32'd0);
                chk("hold_lo", bus.lo_o, 32'd0);
            end
            if (c == 6) chk("hold_stall", bus.perfcnt_muldiv_stall, 32'd2);
            @(posedge clk); #1;
        end
        bus.ready_i = 1'b1;
        idle();
        @(negedge clk);
        chk("hold_res_hi", bus.hi_o, 32'hFFFFFFFF);
        chk("hold_res_lo", bus.lo_o, 32'hFFFFFFF2);
        @(posedge clk); #1;

        // MULT -3 x 5: done low cycles 0-1, high at 2
        set_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            chk("mult_done_timing", 32'(bus.done_o), 32'(c == 2));
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        chk("mult_hi", bus.hi_o, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo_o, 32'hFFFFFFF1);
        @(posedge clk); #1;

        drive(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
        @(negedge clk);
        chk("multu_hi", bus.hi_o, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo_o, 32'h00000001);
        @(posedge clk); #1;

        // DIV -7 / 2: done first high at cycle 33
        set_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        first_done = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.done_o) first_done = c;
            @(posedge clk); #1;
            if (first_done >= 0) break;
        end
        idle();
        chk("div_latency", 32'(first_done), 32'd33);
        @(negedge clk);
        chk("div_lo", bus.lo_o, 32'hFFFFFFFD);
        chk("div_hi", bus.hi_o, 32'hFFFFFFFF);
        @(posedge clk); #1;

        drive(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
        @(negedge clk);
        chk("div_ovf_lo", bus.lo_o, 32'h80000000);
        chk("div_ovf_hi", bus.hi_o, 32'd0);
        @(posedge clk); #1;

        drive(OP_DIVU, 32'd100, 32'd0, -1, 1'b0);
        @(negedge clk);
        chk("divu0_lo", bus.lo_o, 32'hFFFFFFFF);
        chk("divu0_hi", bus.hi_o, 32'd100);
        @(posedge clk); #1;

        // MTHI then MFHI the next cycle
        set_op(OP_MTHI, 32'h12345678, 32'd0);
        @(negedge clk);
        chk("mthi_done", 32'(bus.done_o), 32'd1);
        @(posedge clk); #1;
        set_op(OP_MFHI, 32'd0, 32'd0);
        @(negedge clk);
        chk("mfhi_rdata", bus.rdata_o, 32'h12345678);
        chk("mfhi_done", 32'(bus.done_o), 32'd1);
        @(posedge clk); #1;
        idle();

        // DIVU cancelled at cycle 10
        drive(OP_DIVU, 32'd1000, 32'd3, 10, 1'b0);
        @(negedge clk);
        chk("cancel_busy", 32'(bus.busy_o), 32'd0);
        chk("cancel_hi", bus.hi_o, 32'h12345678);
        chk("cancel_lo", bus.lo_o, 32'hFFFFFFFF);
        @(posedge clk); #1;
        drive(OP_MULTU, 32'd2, 32'd3, -1, 1'b0);
        @(negedge clk);
        chk("after_cancel_lo", bus.lo_o, 32'd6);
        @(posedge clk); #1;

        // Reset in the middle of a divide
        set_op(OP_DIVU, 32'd1000, 32'd7);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        idle();
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_hi", bus.hi_o, 32'd0);
        chk("rst_lo", bus.lo_o, 32'd0);
        @(posedge clk); #1;
        drive(OP_DIVU, 32'd9, 32'd4, -1, 1'b0);
        @(negedge clk);
        chk("divu94_lo", bus.lo_o, 32'd2);
        chk("divu94_hi", bus.hi_o, 32'd1);
        @(posedge clk); #1;

        // Random traffic, back-to-back or with short gaps
        repeat (300) begin
            int op, cancel_at, gap;
            logic [31:0] a, b;
            op        = int'($urandom % 9);
            a         = rnd32();
            b         = rnd32();
            cancel_at = ($urandom % 6 == 0) ? int'($urandom % 40) : -1;
            drive(op, a, b, cancel_at, 1'b1);
            gap = int'($urandom % 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
